// File: rtl/neuron_mac_sm.sv
// neuron_mac_sm: streaming multiply-accumulate producer for the softplus stage.
// Takes (x, w) beats in sign-magnitude Q4.11, seeds the sum with a per-neuron
// bias, and emits one saturated sign-magnitude Q4.11 pre-activation per neuron.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for the first beat of a neuron; loads bias and p_reg
// ACC     | streaming beats; each cycle adds any pending p_reg into acc
// DRAIN   | no more beats; folds the last p_reg into acc
// CONVERT | two's-complement acc -> saturated sign-magnitude result
// HOLD    | result presented; waits for out_ready
module neuron_mac_sm #(
    parameter int ACC_W   = 32,
    parameter int FRAC    = 11,
    parameter int MAX_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x_in,
    input  logic [15:0] w_in,
    input  logic        in_last,
    input  logic [15:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out,
    output logic        sat,
    output logic        len_err
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_CONVERT,
        S_HOLD
    } state_t;

    state_t             state, next_state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   p_reg;
    logic               p_pend;
    logic [CNT_W-1:0]   count;

    logic               in_ready_c;
    logic               first_beat;
    logic               take_beat;
    logic               add_en;
    logic               force_end;
    logic               do_cvt;

    logic [29:0]        prod_full;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   prod_tc;
    logic [ACC_W-1:0]   bias_ext;
    logic [ACC_W-1:0]   bias_tc;
    logic               acc_neg;
    logic [ACC_W-1:0]   acc_abs;
    logic               over;
    logic [14:0]        cvt_mag;
    logic [15:0]        cvt_data;

    // Operand conversion: SM product truncated toward zero, SM bias, both into two's complement
    always_comb begin
        prod_full = {15'b0, x_in[14:0]} * {15'b0, w_in[14:0]};
        prod_ext  = ACC_W'(prod_full >> FRAC);
        // a zero magnitude stays +0 regardless of operand signs
        prod_tc   = ((x_in[15] ^ w_in[15]) && (prod_ext != '0)) ? (~prod_ext + 1'b1) : prod_ext;
        bias_ext  = {{(ACC_W-15){1'b0}}, bias[14:0]};
        // 0x8000 (negative zero) falls out as 0 because -0 == 0
        bias_tc   = bias[15] ? (~bias_ext + 1'b1) : bias_ext;
    end

    // Result conversion: magnitude clip at 0x7FFF, zero always reported as +0
    always_comb begin
        acc_neg  = acc[ACC_W-1];
        acc_abs  = acc_neg ? (~acc + 1'b1) : acc;
        over     = (acc_abs[ACC_W-1:15] != '0);
        cvt_mag  = over ? 15'h7FFF : acc_abs[14:0];
        cvt_data = (cvt_mag == 15'd0) ? 16'h0000 : {acc_neg, cvt_mag};
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state = state;
        in_ready_c = 1'b0;
        first_beat = 1'b0;
        take_beat  = 1'b0;
        add_en     = 1'b0;
        force_end  = 1'b0;
        do_cvt     = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    first_beat = 1'b1;
                    if (in_last) begin
                        next_state = S_DRAIN;
                    end else if (MAX_LEN == 1) begin
                        next_state = S_DRAIN;
                        force_end  = 1'b1;
                    end else begin
                        next_state = S_ACC;
                    end
                end
            end
            S_ACC: begin
                in_ready_c = 1'b1;
                add_en     = p_pend;
                if (in_valid) begin
                    take_beat = 1'b1;
                    if (in_last) begin
                        next_state = S_DRAIN;
                    end else if (count == CNT_W'(MAX_LEN - 1)) begin
                        next_state = S_DRAIN;
                        force_end  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                add_en     = p_pend;
                next_state = S_CONVERT;
            end
            S_CONVERT: begin
                do_cvt     = 1'b1;
                next_state = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Nothing is accepted while reset is held, even though the state reads IDLE
    assign in_ready = in_ready_c & ~reset;

    // Product / accumulator / result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            p_reg    <= '0;
            p_pend   <= 1'b0;
            count    <= '0;
            data_out <= '0;
            sat      <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            if (first_beat) begin
                acc     <= bias_tc;
                p_reg   <= prod_tc;
                p_pend  <= 1'b1;
                count   <= CNT_W'(1);
                len_err <= force_end;
            end else begin
                if (add_en) acc <= acc + p_reg;
                if (take_beat) begin
                    p_reg  <= prod_tc;
                    p_pend <= 1'b1;
                    count  <= count + CNT_W'(1);
                    if (force_end) len_err <= 1'b1;
                end else if (add_en) begin
                    p_pend <= 1'b0;
                end
            end
            if (do_cvt) begin
                data_out <= cvt_data;
                sat      <= over;
            end
        end
    end

endmodule
